// File: rtl/perf_event_counters_if.sv
// Bundles the control, event and readout signals of the event-counter bank.
// The bank drives the slave side; the processor/bench drives the master side.
interface perf_event_counters_if #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 3
);
    // Readout handshake: rd_en sampled at an edge returns rd_data/rd_valid after
    // that same edge; there is no ready, so one request is accepted every cycle.
    logic               start;
    logic               clear;
    logic               halt;
    logic [NUM_EVT-1:0] evt_in;
    logic               rd_en;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_valid;
    logic               rd_err;
    logic [NUM_EVT-1:0] ovf;
    logic               running;
    logic               frozen;
    logic [1:0]         state;

    modport master (
        output start, clear, halt, evt_in, rd_en, rd_sel,
        input  rd_data, rd_valid, rd_err, ovf, running, frozen, state
    );

    modport slave (
        input  start, clear, halt, evt_in, rd_en, rd_sel,
        output rd_data, rd_valid, rd_err, ovf, running, frozen, state
    );
endinterface

// File: rtl/perf_event_counters.sv
// Event-counter bank: per-channel event counters plus a cycle counter, frozen on
// processor halt and read back through a registered select port.
module perf_event_counters #(
    parameter int NUM_EVT  = 6,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    parameter int SEL_W    = 3
) (
    input logic clk,
    input logic rst_n,
    perf_event_counters_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_EVT];
    logic [CNT_W-1:0]   cyc;
    logic [NUM_EVT-1:0] ovf;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_valid;
    logic               rd_err;
    logic [CNT_W-1:0]   rd_mux;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur);
        if (cur == ALL_ONES)
            return (SATURATE != 0) ? ALL_ONES : '0;
        return cur + 1'b1;
    endfunction

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (bus.rd_sel == SEL_W'(i))
                rd_mux = cnt[i];
        end
        if (bus.rd_sel == SEL_W'(NUM_EVT))
            rd_mux = cyc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cyc      <= '0;
            ovf      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            for (int i = 0; i < NUM_EVT; i++)
                cnt[i] <= '0;
        end else begin
            // Readout captures the pre-update counter value of this edge.
            rd_valid <= bus.rd_en;
            rd_err   <= bus.rd_en && (bus.rd_sel > SEL_W'(NUM_EVT));
            if (bus.rd_en)
                rd_data <= rd_mux;

            if (bus.clear) begin
                cyc <= '0;
                ovf <= '0;
                for (int i = 0; i < NUM_EVT; i++)
                    cnt[i] <= '0;
            end else if (state == RUN) begin
                cyc <= bump(cyc);
                for (int i = 0; i < NUM_EVT; i++) begin
                    if (bus.evt_in[i]) begin
                        cnt[i] <= bump(cnt[i]);
                        if (cnt[i] == ALL_ONES)
                            ovf[i] <= 1'b1;
                    end
                end
            end

            // The halt cycle itself is still counted above before freezing.
            case (state)
                IDLE:    if (bus.start) state <= RUN;
                RUN:     if (bus.halt)  state <= FROZEN;
                FROZEN:  if (bus.clear) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_err   = rd_err;
    assign bus.ovf      = ovf;
    assign bus.running  = (state == RUN);
    assign bus.frozen   = (state == FROZEN);
    assign bus.state    = state;
endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a default-width bank plus two 4-bit
// banks (saturating and wrapping) for the overflow corner cases.
module tb_perf_event_counters;
  logic clk;
  logic rst_n;

  perf_event_counters_if #(.NUM_EVT(6), .CNT_W(32), .SEL_W(3)) m ();
  perf_event_counters_if #(.NUM_EVT(6), .CNT_W(4),  .SEL_W(3)) s ();
  perf_event_counters_if #(.NUM_EVT(6), .CNT_W(4),  .SEL_W(3)) w ();

  perf_event_counters #(.NUM_EVT(6), .CNT_W(32), .SATURATE(1), .SEL_W(3)) dut_main (
    .clk(clk), .rst_n(rst_n), .bus(m.slave)
  );
  perf_event_counters #(.NUM_EVT(6), .CNT_W(4), .SATURATE(1), .SEL_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(s.slave)
  );
  perf_event_counters #(.NUM_EVT(6), .CNT_W(4), .SATURATE(0), .SEL_W(3)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(w.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        err;
  } rd_vec_t;

  rd_vec_t vec[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string name);
    m.rd_en  = 1'b1;
    m.rd_sel = sel;
    tick();
    check({name, "_valid"}, {31'd0, m.rd_valid}, 32'd1);
    check(name, m.rd_data, exp);
    m.rd_en = 1'b0;
  endtask

  task automatic idle_inputs();
    m.start = 0; m.clear = 0; m.halt = 0; m.evt_in = '0; m.rd_en = 0; m.rd_sel = '0;
    s.start = 0; s.clear = 0; s.halt = 0; s.evt_in = '0; s.rd_en = 0; s.rd_sel = '0;
    w.start = 0; w.clear = 0; w.halt = 0; w.evt_in = '0; w.rd_en = 0; w.rd_sel = '0;
  endtask

  initial begin
    vec[0] = '{3'd0, 32'd5, 1'b0};
    vec[1] = '{3'd1, 32'd0, 1'b0};
    vec[2] = '{3'd2, 32'd0, 1'b0};
    vec[3] = '{3'd3, 32'd0, 1'b0};
    vec[4] = '{3'd4, 32'd0, 1'b0};
    vec[5] = '{3'd5, 32'd0, 1'b0};
    vec[6] = '{3'd6, 32'd5, 1'b0};
    vec[7] = '{3'd7, 32'd0, 1'b1};
    vec[8] = '{3'd0, 32'd5, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_rd_data", m.rd_data, 32'd0);
    check("rst_rd_valid", {31'd0, m.rd_valid}, 32'd0);
    check("rst_rd_err", {31'd0, m.rd_err}, 32'd0);
    check("rst_ovf", {26'd0, m.ovf}, 32'd0);
    check("rst_running", {31'd0, m.running}, 32'd0);
    check("rst_frozen", {31'd0, m.frozen}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: ten cycles of channel-0 events
    m.start = 1; tick(); m.start = 0;
    m.evt_in = 6'b000001;
    repeat (10) tick();
    m.evt_in = '0;
    check("t1_running", {31'd0, m.running}, 32'd1);
    rd(3'd6, 32'd10, "t1_cycle");
    rd(3'd0, 32'd10, "t1_cnt0");
    rd(3'd1, 32'd0,  "t1_cnt1");

    // 2: clear in RUN, then halt on the fifth event cycle
    m.clear = 1; tick(); m.clear = 0;
    check("t2_clear_running", {31'd0, m.running}, 32'd1);
    m.evt_in = 6'b000001;
    repeat (4) tick();
    m.halt = 1; tick(); m.halt = 0;
    repeat (4) tick();
    m.evt_in = '0;
    check("t2_frozen", {31'd0, m.frozen}, 32'd1);
    check("t2_not_running", {31'd0, m.running}, 32'd0);
    m.start = 1; tick(); m.start = 0;
    check("t2_start_ignored", {31'd0, m.frozen}, 32'd1);

    // 4: back-to-back readout in FROZEN
    m.rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      m.rd_sel = vec[i].sel;
      exp_q.push_back(vec[i].data);
      tick();
      check($sformatf("t4_valid_%0d", i), {31'd0, m.rd_valid}, 32'd1);
      check($sformatf("t4_data_%0d", i), m.rd_data, exp_q.pop_front());
      check($sformatf("t4_err_%0d", i), {31'd0, m.rd_err}, {31'd0, vec[i].err});
    end
    m.rd_en = 1'b0;
    tick();
    check("t4_idle_valid", {31'd0, m.rd_valid}, 32'd0);
    check("t4_idle_err", {31'd0, m.rd_err}, 32'd0);
    check("t4_hold_data", m.rd_data, 32'd5);

    // 5: clear in FROZEN -> IDLE, events ignored, restart, clear beats events
    m.clear = 1; tick(); m.clear = 0;
    check("t5_idle_running", {31'd0, m.running}, 32'd0);
    check("t5_idle_frozen", {31'd0, m.frozen}, 32'd0);
    m.evt_in = 6'b111111;
    repeat (3) tick();
    m.evt_in = '0;
    rd(3'd0, 32'd0, "t5_idle_cnt0");
    rd(3'd6, 32'd0, "t5_idle_cycle");
    m.start = 1; tick(); m.start = 0;
    m.evt_in = 6'b111111;
    repeat (3) tick();
    m.clear = 1; tick(); m.clear = 0;
    m.evt_in = '0;
    check("t5_clear_running", {31'd0, m.running}, 32'd1);
    rd(3'd6, 32'd0, "t5_clr_cycle");
    rd(3'd3, 32'd0, "t5_clr_cnt3");
    m.evt_in = 6'b000010;
    repeat (2) tick();
    m.evt_in = '0;
    rd(3'd1, 32'd2, "t5_restart_cnt1");
    m.clear = 1; m.halt = 1; m.evt_in = 6'b111111;
    tick();
    m.clear = 0; m.halt = 0; m.evt_in = '0;
    check("t5_clrhalt_frozen", {31'd0, m.frozen}, 32'd1);
    rd(3'd0, 32'd0, "t5_clrhalt_cnt0");
    rd(3'd6, 32'd0, "t5_clrhalt_cycle");
    m.clear = 1; tick(); m.clear = 0;
    check("t5_back_idle", {31'd0, m.running | m.frozen}, 32'd0);

    // 3: 4-bit overflow, saturating vs wrapping
    s.start = 1; w.start = 1; tick(); s.start = 0; w.start = 0;
    s.evt_in = 6'b000010; w.evt_in = 6'b000010;
    repeat (15) tick();
    check("t3_sat_ovf_at_max", {26'd0, s.ovf}, 32'd0);
    check("t3_wrap_ovf_at_max", {26'd0, w.ovf}, 32'd0);
    repeat (5) tick();
    s.evt_in = '0; w.evt_in = '0;
    s.halt = 1; w.halt = 1; tick(); s.halt = 0; w.halt = 0;
    s.rd_en = 1; w.rd_en = 1; s.rd_sel = 3'd1; w.rd_sel = 3'd1;
    tick();
    check("t3_sat_cnt1", {28'd0, s.rd_data}, 32'd15);
    check("t3_wrap_cnt1", {28'd0, w.rd_data}, 32'd4);
    s.rd_sel = 3'd6; w.rd_sel = 3'd6;
    tick();
    check("t3_sat_cycle", {28'd0, s.rd_data}, 32'd15);
    check("t3_wrap_cycle", {28'd0, w.rd_data}, 32'd5);
    s.rd_en = 0; w.rd_en = 0;
    check("t3_sat_ovf", {26'd0, s.ovf}, 32'd2);
    check("t3_wrap_ovf", {26'd0, w.ovf}, 32'd2);

    // 6: asynchronous reset between edges mid-RUN
    m.start = 1; tick(); m.start = 0;
    m.evt_in = 6'b000011;
    repeat (3) tick();
    m.evt_in = '0;
    rd(3'd6, 32'd3, "t6_pre_cycle");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_rd_data", m.rd_data, 32'd0);
    check("t6_async_running", {31'd0, m.running}, 32'd0);
    check("t6_async_state", {30'd0, m.state}, 32'd0);
    #1;
    rst_n = 1'b1;
    m.evt_in = 6'b111111;
    repeat (3) tick();
    m.evt_in = '0;
    rd(3'd0, 32'd0, "t6_post_cnt0");
    rd(3'd6, 32'd0, "t6_post_cycle");
    check("t6_post_running", {31'd0, m.running}, 32'd0);
    check("t6_post_ovf", {26'd0, m.ovf}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
